uart_arbiter: RTL and testbench
===============================

# uart_arbiter

Shares the single UART core among up to `N_CPU` j1 CPU cores. Each CPU requests ownership with a level request and is granted round-robin. Only the owner's access strobes reach the UART, and only the owner sees UART read data. An optional hold timer preempts an owner that keeps the UART while others wait. The block sits between the CPU cores' UART ports and the UART core.

## Interface
Parameters:
- `N_CPU`, 3: number of requesting CPUs, 2..8.
- `DATA_W`, 8: UART data bus width.
- `HOLD_MAX`, 0: maximum cycles one owner may hold the UART while another request is pending. 0 disables preemption.

Ports:
- `clk`  in  1: clock; the block runs on this single clock.
- `rst`  in  1: reset, synchronous, active-high.
- `cpu_req`  in  N_CPU: per-CPU ownership request (level).
- `cpu_gnt`  out  N_CPU: per-CPU grant, one-hot or zero, registered.
- `cpu_uart_rd_o`  in  N_CPU: per-CPU read strobe.
- `cpu_uart_wr_o`  in  N_CPU: per-CPU write strobe.
- `cpu_uart_adr_o`  in  N_CPU: per-CPU register address (1 bit each).
- `cpu_uart_dat_o`  in  N_CPU*DATA_W: per-CPU write data. CPU i uses bits [i*DATA_W +: DATA_W].
- `cpu_uart_dat_i`  out  N_CPU*DATA_W: per-CPU read data, same slicing.
- `uart_dout`  in  DATA_W: UART read data.
- `uart_rd`  out  1: UART read strobe.
- `uart_wr`  out  1: UART write strobe.
- `uart_addr`  out  1: UART register address.
- `uart_din`  out  DATA_W: UART write data.
- `uart_busy`  out  1: high while any grant is held.
- `uart_owner`  out  clog2(N_CPU): index of current owner. Holds the last owner when idle.

## Operation
- FSM states: IDLE, GRANT, RELEASE.
- **IDLE**
  - If any `cpu_req` is high, select the first requester at or after `ptr+1`, wrapping modulo `N_CPU`.
  - Set its `cpu_gnt` bit, load `uart_owner` and `ptr` with its index, clear `hold_cnt`, and go to GRANT.
  - Otherwise stay in IDLE with all grants 0.
- **GRANT**
  - If the owner's `cpu_req` is low, clear the grant and go to RELEASE.
  - Otherwise, if `HOLD_MAX`≠0, `hold_cnt` = `HOLD_MAX`-1, any other `cpu_req` is high, and the owner's `rd`/`wr` are both low this cycle: clear the grant and go to RELEASE (preemption). A strobe cycle is never cut.
  - Otherwise increment `hold_cnt`. It saturates at `HOLD_MAX`-1.
  - `hold_cnt` counts only while another request is pending; it is cleared on any cycle with no other request.
- **RELEASE**: one turnaround cycle with no grant, then IDLE.
- **Datapath (combinational from registered `cpu_gnt`)**
  - `uart_rd` = OR over i of (`rd_o[i]` & `gnt[i]`). `uart_wr` and `uart_addr` are formed the same way.
  - `uart_din` = the owner's `dat_o` slice when `uart_busy`, else 0.
  - `cpu_uart_dat_i` slice i = `uart_dout` when `gnt[i]`, else 0.
  - Strobes from non-owners are dropped. They are not queued.
- A preempted owner whose `req` stays high waits its next round-robin turn. Because `ptr` has advanced past it, every other requester is served first.
- `hold_cnt` width is clog2(`HOLD_MAX`+1).

## Timing
- **Reset values:** state IDLE, `cpu_gnt`=0, `uart_busy`=0, `uart_owner`=0, `ptr`=`N_CPU`-1 so CPU0 wins first, `hold_cnt`=0. As a result `uart_rd`/`uart_wr`/`uart_addr`=0, `uart_din`=0, and all `cpu_uart_dat_i`=0.
- **Grant latency:** `req` sampled high at edge k in IDLE → `gnt` high after edge k. The first passed-through strobe is in cycle k+1.
- **Release:** owner `req` sampled low at edge k → `gnt` low after k, RELEASE in cycle k+1, IDLE in k+2. The earliest next grant is after edge k+2 (2-cycle gap with no owner).
- **Preemption:** grant drops on the edge where the timeout condition is true, followed by the same RELEASE gap.
- **Simultaneous requests:** resolved in one cycle by the round-robin pointer. Only one grant is ever high.
- **`req` deasserted same cycle it is granted:** the grant still issues, then releases on the next edge.
- **Reset mid-grant:** grant drops the cycle after `rst` is sampled. Any in-flight strobe is cut, and `ptr` returns to `N_CPU`-1.

## Test plan
- **Reset:** hold `rst` 3 cycles with all `req`=1 → all outputs 0 during reset. `cpu_gnt`=3'b001 one cycle after `rst` falls.
- **Single requester:** CPU1 `req`=1, writes `adr`=1, `dat`=8'hA5 → `uart_wr`=1, `uart_addr`=1, `uart_din`=8'hA5. With `uart_dout`=8'h3C, CPU1's `dat_i`=8'h3C while CPU0/CPU2 `dat_i`=0.
- **Round-robin:** all three `req` held, each owner drops `req` after 4 cycles → grant order 0,1,2,0. Exactly 2 idle cycles between grants.
- **Non-owner masking:** CPU0 owns; CPU2 pulses `wr`, `dat`=8'hFF → `uart_wr` and `uart_din` unaffected by CPU2.
- **Preemption:** `HOLD_MAX`=16. CPU0 holds `req` and keeps `rd` asserted through hold cycles 14–17 while CPU1 requests from cycle 0 → CPU0 keeps the grant while strobing and loses it on the first strobe-free cycle at or after the limit. CPU1 is granted 2 cycles later. CPU0 is re-granted only after CPU1 releases.
- **Reset mid-grant:** CPU2 owns with `wr` high, `rst` pulsed → `uart_wr`=0 the next cycle. The first post-reset grant goes to the lowest requesting index.

Source files
------------

// File: rtl/uart_arbiter_if.sv
// rtl/uart_arbiter_if.sv - CPU-side and UART-side signal bundle for uart_arbiter
interface uart_arbiter_if #(
    parameter int N_CPU  = 3,
    parameter int DATA_W = 8
);
    localparam int OWN_W = (N_CPU > 1) ? $clog2(N_CPU) : 1;

    logic [N_CPU-1:0]        cpu_req;
    logic [N_CPU-1:0]        cpu_gnt;
    logic [N_CPU-1:0]        cpu_uart_rd_o;
    logic [N_CPU-1:0]        cpu_uart_wr_o;
    logic [N_CPU-1:0]        cpu_uart_adr_o;
    logic [N_CPU*DATA_W-1:0] cpu_uart_dat_o;
    logic [N_CPU*DATA_W-1:0] cpu_uart_dat_i;
    logic [DATA_W-1:0]       uart_dout;
    logic                    uart_rd;
    logic                    uart_wr;
    logic                    uart_addr;
    logic [DATA_W-1:0]       uart_din;
    logic                    uart_busy;
    logic [OWN_W-1:0]        uart_owner;

    modport master (
        output cpu_req, cpu_uart_rd_o, cpu_uart_wr_o, cpu_uart_adr_o, cpu_uart_dat_o, uart_dout,
        input  cpu_gnt, cpu_uart_dat_i, uart_rd, uart_wr, uart_addr, uart_din, uart_busy, uart_owner
    );

    modport slave (
        input  cpu_req, cpu_uart_rd_o, cpu_uart_wr_o, cpu_uart_adr_o, cpu_uart_dat_o, uart_dout,
        output cpu_gnt, cpu_uart_dat_i, uart_rd, uart_wr, uart_addr, uart_din, uart_busy, uart_owner
    );
endinterface

// File: rtl/uart_arbiter.sv
// rtl/uart_arbiter.sv - round-robin arbiter sharing one UART core among N_CPU j1 cores
module uart_arbiter #(
    parameter int N_CPU    = 3,
    parameter int DATA_W   = 8,
    parameter int HOLD_MAX = 0
) (
    input  logic          clk,
    input  logic          rst,
    uart_arbiter_if.slave bus
);
    localparam int OWN_W  = (N_CPU > 1) ? $clog2(N_CPU) : 1;
    localparam int HOLD_W = (HOLD_MAX > 0) ? $clog2(HOLD_MAX + 1) : 1;
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'((HOLD_MAX > 0) ? HOLD_MAX - 1 : 0);
    localparam logic [OWN_W-1:0]  PTR_RST   = OWN_W'(N_CPU - 1);

    typedef enum logic [1:0] {S_IDLE, S_GRANT, S_RELEASE} state_t;

    state_t              r_state, w_state_nxt;
    logic [N_CPU-1:0]    r_gnt, w_gnt_nxt;
    logic [OWN_W-1:0]    r_owner, w_owner_nxt;
    logic [OWN_W-1:0]    r_ptr, w_ptr_nxt;
    logic [HOLD_W-1:0]   r_hold, w_hold_nxt;

    logic                w_found;
    logic [OWN_W-1:0]    w_pick;
    logic                w_own_req;
    logic                w_own_strobe;
    logic                w_others;
    logic                w_timeout;
    logic [DATA_W-1:0]       w_din;
    logic [N_CPU*DATA_W-1:0] w_dat_i;

    // Search by distance k from the pointer so the requester just after ptr wins.
    always_comb begin : rr_pick
        w_found = 1'b0;
        w_pick  = r_ptr;
        for (int k = 1; k <= N_CPU; k++) begin
            for (int i = 0; i < N_CPU; i++) begin
                if (!w_found && bus.cpu_req[i] && (int'(r_ptr) == (i - k + N_CPU) % N_CPU)) begin
                    w_found = 1'b1;
                    w_pick  = OWN_W'(i);
                end
            end
        end
    end

    assign w_own_req    = |(bus.cpu_req & r_gnt);
    assign w_own_strobe = |((bus.cpu_uart_rd_o | bus.cpu_uart_wr_o) & r_gnt);
    assign w_others     = |(bus.cpu_req & ~r_gnt);
    // A strobing owner is never cut; preemption waits for a quiet cycle.
    assign w_timeout    = (HOLD_MAX != 0) && (r_hold == HOLD_LAST) && w_others && !w_own_strobe;

    always_ff @(posedge clk) begin : state_reg
        if (rst) begin
            r_state <= S_IDLE;
            r_gnt   <= '0;
            r_owner <= '0;
            r_ptr   <= PTR_RST;
            r_hold  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_gnt   <= w_gnt_nxt;
            r_owner <= w_owner_nxt;
            r_ptr   <= w_ptr_nxt;
            r_hold  <= w_hold_nxt;
        end
    end

    always_comb begin : next_state
        w_state_nxt = r_state;
        w_gnt_nxt   = r_gnt;
        w_owner_nxt = r_owner;
        w_ptr_nxt   = r_ptr;
        w_hold_nxt  = r_hold;
        case (r_state)
            S_IDLE: begin
                if (w_found) begin
                    w_state_nxt = S_GRANT;
                    w_gnt_nxt   = N_CPU'(1) << w_pick;
                    w_owner_nxt = w_pick;
                    w_ptr_nxt   = w_pick;
                    w_hold_nxt  = '0;
                end
            end
            S_GRANT: begin
                if (!w_own_req || w_timeout) begin
                    w_state_nxt = S_RELEASE;
                    w_gnt_nxt   = '0;
                end else if (!w_others) begin
                    w_hold_nxt = '0;
                end else if (r_hold != HOLD_LAST) begin
                    w_hold_nxt = r_hold + 1'b1;
                end
            end
            S_RELEASE: w_state_nxt = S_IDLE;
            default:   w_state_nxt = S_IDLE;
        endcase
    end

    always_comb begin : outputs
        w_din   = '0;
        w_dat_i = '0;
        for (int i = 0; i < N_CPU; i++) begin
            if (r_gnt[i]) begin
                w_din                        = w_din | bus.cpu_uart_dat_o[i*DATA_W +: DATA_W];
                w_dat_i[i*DATA_W +: DATA_W]  = bus.uart_dout;
            end
        end
    end

    assign bus.cpu_gnt        = r_gnt;
    assign bus.uart_busy      = |r_gnt;
    assign bus.uart_owner     = r_owner;
    assign bus.uart_rd        = |(bus.cpu_uart_rd_o & r_gnt);
    assign bus.uart_wr        = |(bus.cpu_uart_wr_o & r_gnt);
    assign bus.uart_addr      = |(bus.cpu_uart_adr_o & r_gnt);
    assign bus.uart_din       = w_din;
    assign bus.cpu_uart_dat_i = w_dat_i;
endmodule

// File: tb/tb_uart_arbiter.sv
// tb/tb_uart_arbiter.sv - randomized self-checking bench for uart_arbiter against a behavioural model
module tb_uart_arbiter;
    localparam int N  = 3;
    localparam int DW = 8;
    localparam int HM = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    uart_arbiter_if #(.N_CPU(N), .DATA_W(DW)) bus();

    uart_arbiter #(.N_CPU(N), .DATA_W(DW), .HOLD_MAX(HM)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference: who owns the UART, how long, and whether a turnaround cycle is pending.
    int m_owner = -1;
    int m_last  = 0;
    int m_ptr   = N - 1;
    int m_age   = 0;
    int m_wait  = 0;
    bit m_turn  = 1'b0;

    int  dut_grants[$];
    int  dut_gaps[$];
    int  dut_lens[$];
    bit  prev_busy = 1'b0;
    int  run_len   = 0;
    int  idle_len  = 0;

    function automatic bit sel(input logic [N-1:0] v, input int i);
        logic [N-1:0] t;
        t = v >> i;
        return t[0];
    endfunction

    function automatic logic [DW-1:0] slice(input logic [N*DW-1:0] v, input int i);
        logic [N*DW-1:0] t;
        t = v >> (i * DW);
        return t[DW-1:0];
    endfunction

    function automatic int qget(input int q[$], input int j);
        return (j < q.size()) ? q[j] : -1;
    endfunction

    function automatic void model_step();
        int  pick;
        bit  others;
        if (rst) begin
            m_owner = -1; m_last = 0; m_ptr = N - 1; m_turn = 1'b0;
            return;
        end
        if (m_owner < 0) begin
            if (m_turn) begin
                m_turn = 1'b0;
            end else begin
                pick = -1;
                for (int k = 1; k <= N; k++)
                    if (pick < 0 && sel(bus.cpu_req, (m_ptr + k) % N)) pick = (m_ptr + k) % N;
                if (pick >= 0) begin
                    m_owner = pick; m_last = pick; m_ptr = pick; m_age = 0; m_wait = 0;
                end
            end
        end else begin
            others = |(bus.cpu_req & ~(N'(1) << m_owner));
            if (!sel(bus.cpu_req, m_owner) ||
                (HM > 0 && others && m_wait >= HM - 1 &&
                 !sel(bus.cpu_uart_rd_o | bus.cpu_uart_wr_o, m_owner))) begin
                m_owner = -1;
                m_turn  = 1'b1;
            end else begin
                m_age++;
                m_wait = others ? m_wait + 1 : 0;
            end
        end
    endfunction

    task automatic check_outputs();
        logic [N-1:0]    e_gnt;
        logic [N*DW-1:0] e_dati;
        logic [DW-1:0]   e_din;
        bit              own;
        own    = (m_owner >= 0);
        e_gnt  = own ? (N'(1) << m_owner) : '0;
        e_dati = own ? ((N*DW)'(bus.uart_dout) << (m_owner * DW)) : '0;
        e_din  = own ? slice(bus.cpu_uart_dat_o, m_owner) : '0;
        check("gnt",   32'(bus.cpu_gnt),        32'(e_gnt));
        check("busy",  32'(bus.uart_busy),      32'(own));
        check("owner", 32'(bus.uart_owner),     32'(m_last));
        check("rd",    32'(bus.uart_rd),        32'(own && sel(bus.cpu_uart_rd_o, m_owner)));
        check("wr",    32'(bus.uart_wr),        32'(own && sel(bus.cpu_uart_wr_o, m_owner)));
        check("addr",  32'(bus.uart_addr),      32'(own && sel(bus.cpu_uart_adr_o, m_owner)));
        check("din",   32'(bus.uart_din),       32'(e_din));
        check("dat_i", 32'(bus.cpu_uart_dat_i), 32'(e_dati));
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        check_outputs();
        if (bus.uart_busy) begin
            if (!prev_busy) begin
                dut_grants.push_back(int'(bus.uart_owner));
                dut_gaps.push_back(idle_len);
                run_len = 0;
            end
            run_len++;
        end else begin
            if (prev_busy) dut_lens.push_back(run_len);
            idle_len = prev_busy ? 1 : idle_len + 1;
        end
        prev_busy = bus.uart_busy;
    endtask

    task automatic idle_inputs();
        bus.cpu_req        = '0;
        bus.cpu_uart_rd_o  = '0;
        bus.cpu_uart_wr_o  = '0;
        bus.cpu_uart_adr_o = '0;
        bus.cpu_uart_dat_o = '0;
        bus.uart_dout      = '0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        dut_grants.delete(); dut_gaps.delete(); dut_lens.delete();
    endtask

    initial begin
        logic [N-1:0] r;

        // Reset held with everything asserted.
        rst = 1'b1;
        bus.cpu_req = '1; bus.cpu_uart_rd_o = '1; bus.cpu_uart_wr_o = '1;
        bus.cpu_uart_adr_o = '1; bus.cpu_uart_dat_o = '1; bus.uart_dout = 8'h5A;
        repeat (3) tick();
        rst = 1'b0;
        tick();
        check("reset_first_gnt", 32'(bus.cpu_gnt), 32'h1);

        // Single requester passthrough.
        do_reset();
        bus.cpu_req = 3'b010;
        tick();
        bus.cpu_uart_wr_o = 3'b010; bus.cpu_uart_adr_o = 3'b010;
        bus.cpu_uart_dat_o = 24'h00A500; bus.uart_dout = 8'h3C;
        #1;
        check("single_wr",    32'(bus.uart_wr),        32'h1);
        check("single_addr",  32'(bus.uart_addr),      32'h1);
        check("single_din",   32'(bus.uart_din),       32'hA5);
        check("single_dat_i", 32'(bus.cpu_uart_dat_i), 32'h003C00);
        tick();

        // Round-robin with each owner dropping req after 4 granted cycles.
        do_reset();
        bus.cpu_req = '1;
        repeat (30) begin
            tick();
            r = '1;
            if (m_owner >= 0 && m_age >= 3) r = r & ~(N'(1) << m_owner);
            bus.cpu_req = r;
        end
        check("rr_g0", qget(dut_grants, 0), 0);
        check("rr_g1", qget(dut_grants, 1), 1);
        check("rr_g2", qget(dut_grants, 2), 2);
        check("rr_g3", qget(dut_grants, 3), 0);
        for (int j = 1; j < 4; j++) check("rr_gap", qget(dut_gaps, j), 2);
        check("rr_len", qget(dut_lens, 0), 4);

        // Non-owner strobes are dropped.
        do_reset();
        bus.cpu_req = 3'b101;
        tick();
        bus.cpu_uart_wr_o = 3'b100; bus.cpu_uart_adr_o = 3'b100;
        bus.cpu_uart_dat_o = 24'hFF0012;
        #1;
        check("mask_wr",   32'(bus.uart_wr),   32'h0);
        check("mask_addr", 32'(bus.uart_addr), 32'h0);
        check("mask_din",  32'(bus.uart_din),  32'h12);
        tick();

        // Preemption: CPU0 strobes through hold cycles 14..17, CPU1 waits from the start.
        do_reset();
        bus.cpu_req = 3'b011;
        repeat (60) begin
            tick();
            r = bus.cpu_req;
            if (m_owner == 1 && m_age >= 4) r[1] = 1'b0;
            bus.cpu_req = r;
            bus.cpu_uart_rd_o = (m_owner == 0 && m_age >= 14 && m_age <= 17) ? 3'b001 : 3'b000;
        end
        check("pre_g0",   qget(dut_grants, 0), 0);
        check("pre_len",  qget(dut_lens, 0), 19);
        check("pre_g1",   qget(dut_grants, 1), 1);
        check("pre_gap",  qget(dut_gaps, 1), 2);
        check("pre_g2",   qget(dut_grants, 2), 0);
        check("pre_len1", qget(dut_lens, 1), 5);

        // Reset while CPU2 is mid-write.
        do_reset();
        bus.cpu_req = 3'b100;
        tick();
        check("mid_owner", 32'(bus.uart_owner), 32'h2);
        bus.cpu_uart_wr_o = 3'b100; bus.cpu_req = 3'b111;
        #1;
        check("mid_wr_live", 32'(bus.uart_wr), 32'h1);
        rst = 1'b1;
        tick();
        check("mid_wr_cut", 32'(bus.uart_wr), 32'h0);
        rst = 1'b0;
        tick();
        check("mid_regrant", 32'(bus.cpu_gnt), 32'h1);

        // Random traffic with sticky requests and occasional reset.
        do_reset();
        repeat (3000) begin
            r = bus.cpu_req;
            for (int i = 0; i < N; i++) if ($urandom_range(0, 11) == 0) r[i] = ~r[i];
            bus.cpu_req        = r;
            bus.cpu_uart_rd_o  = N'($urandom) & N'($urandom);
            bus.cpu_uart_wr_o  = N'($urandom) & N'($urandom);
            bus.cpu_uart_adr_o = N'($urandom);
            bus.cpu_uart_dat_o = (N*DW)'($urandom);
            bus.uart_dout      = DW'($urandom);
            rst                = ($urandom_range(0, 399) == 0);
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
